// File: rtl/seq_pkg.sv
// Shared types and constants for the unified-memory fetch/data sequencer.
package seq_pkg;

    typedef enum logic [2:0] {
        BOOT,
        FETCH,
        DECODE,
        DATA,
        COMMIT,
        ERROR
    } state_t;

    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // True when the instruction needs a data-memory access after fetch.
    function automatic logic is_mem_op(input logic [31:0] instr);
        return (instr[6:0] == OP_LOAD) || (instr[6:0] == OP_STORE);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Counts request cycles spent waiting for mem_ready; expired marks the last
// cycle a request may still complete before it is declared a bus error.
module wait_timer #(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CW = $clog2(MAX_WAIT);

    logic [CW-1:0] cnt;

    // Wait counter: cleared outside requests, advanced on each unanswered request cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/core_mem_sequencer.sv
// Multi-cycle sequencer sharing one single-port memory between instruction
// fetch and data access for a single-cycle RV32I core.
//
// state  | meaning
// -------+---------------------------------------------------------------
// BOOT   | one idle cycle after reset release
// FETCH  | read instruction at core_pc (misaligned pc -> ERROR, no request)
// DECODE | core combinational settle; pick DATA for load/store
// DATA   | single load/store at core_alu_result
// COMMIT | one-cycle core_en pulse, retire count advances
// ERROR  | sticky bus error, no requests, until reset
module core_mem_sequencer
    import seq_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      core_pc,
    input  logic             core_mem_write,
    input  logic [31:0]      core_alu_result,
    input  logic [31:0]      core_write_data,
    output logic [31:0]      core_instr,
    output logic [31:0]      core_read_data,
    output logic             core_en,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    output logic             bus_error,
    output logic [CNT_W-1:0] instr_count
);

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        instr_q;
    logic [31:0]        rdata_q;
    logic [CNT_W-1:0]   count_q;
    logic               fetch_ok;
    logic               req_active;
    logic               xfer_done;
    logic               expired;

    assign fetch_ok   = (core_pc[1:0] == 2'b00);
    assign req_active = ((state == FETCH) && fetch_ok) || (state == DATA);
    assign xfer_done  = req_active && mem_ready;

    // The timer restarts whenever we are outside a request state, so every
    // entry into FETCH or DATA begins from zero.
    wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (!((state == FETCH) || (state == DATA))),
        .inc     (req_active && !mem_ready),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a completion on the expiring cycle still wins.
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:   state_nxt = FETCH;
            FETCH: begin
                if (!fetch_ok)      state_nxt = ERROR;
                else if (mem_ready) state_nxt = DECODE;
                else if (expired)   state_nxt = ERROR;
            end
            DECODE: state_nxt = is_mem_op(instr_q) ? DATA : COMMIT;
            DATA: begin
                if (mem_ready)      state_nxt = COMMIT;
                else if (expired)   state_nxt = ERROR;
            end
            COMMIT: state_nxt = FETCH;
            ERROR:  state_nxt = ERROR;
            default: state_nxt = BOOT;
        endcase
    end

    // Instruction, load data and retire-count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= NOP_INSTR;
            rdata_q <= '0;
            count_q <= '0;
        end else begin
            if ((state == FETCH) && xfer_done) begin
                instr_q <= mem_rdata;
            end
            if ((state == DATA) && xfer_done && (instr_q[6:0] == OP_LOAD)) begin
                rdata_q <= mem_rdata;
            end
            if (state == COMMIT) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    // Memory and core-facing outputs decoded from the current state.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        core_en   = 1'b0;
        bus_error = 1'b0;
        case (state)
            FETCH: begin
                mem_req  = fetch_ok;
                mem_addr = core_pc;
            end
            DATA: begin
                mem_req   = 1'b1;
                mem_we    = core_mem_write;
                mem_addr  = core_alu_result;
                mem_wdata = core_write_data;
            end
            COMMIT:  core_en   = 1'b1;
            ERROR:   bus_error = 1'b1;
            default: ;
        endcase
    end

    assign core_instr     = instr_q;
    assign core_read_data = rdata_q;
    assign instr_count    = count_q;

endmodule

// File: tb/tb_core_mem_sequencer.sv
// Randomized bench for core_mem_sequencer: the bench plays memory and core,
// and predicts each instruction's outcome from its type and wait counts.
module tb_core_mem_sequencer;

    localparam int MAX_WAIT = 16;
    localparam int CNT_W    = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [31:0]      core_pc = '0;
    logic             core_mem_write = 1'b0;
    logic [31:0]      core_alu_result = '0;
    logic [31:0]      core_write_data = '0;
    logic [31:0]      core_instr;
    logic [31:0]      core_read_data;
    logic             core_en;
    logic             mem_req;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata = '0;
    logic             mem_ready = 1'b0;
    logic             bus_error;
    logic [CNT_W-1:0] instr_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_count = '0;
    logic [31:0] exp_rdata = '0;

    core_mem_sequencer #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .core_pc         (core_pc),
        .core_mem_write  (core_mem_write),
        .core_alu_result (core_alu_result),
        .core_write_data (core_write_data),
        .core_instr      (core_instr),
        .core_read_data  (core_read_data),
        .core_en         (core_en),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_ready       (mem_ready),
        .bus_error       (bus_error),
        .instr_count     (instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reset pulse released on a falling edge; the model restarts with it.
    task automatic do_reset();
        reset     = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        reset     = 1'b1;
        exp_count = '0;
        exp_rdata = '0;
    endtask

    // Plays one instruction from its FETCH cycle through COMMIT. Must be
    // entered on the falling edge just before the sequencer is in FETCH.
    task automatic run_instr(input logic [31:0] pc, input logic [31:0] instr,
                             input int wf, input int wd,
                             input logic [31:0] alu, input logic [31:0] wdata,
                             input logic [31:0] ldata);
        logic is_load;
        logic is_store;
        logic is_mem;
        int   cyc;
        int   fn;
        int   dn;
        int   bad;
        bit   fdone;
        bit   seen;
        int   exp_lat;
        is_load  = (instr[6:0] == 7'b0000011);
        is_store = (instr[6:0] == 7'b0100011);
        is_mem   = is_load || is_store;
        cyc = 0; fn = 0; dn = 0; bad = 0; fdone = 0; seen = 0;
        core_pc         = pc;
        core_alu_result = alu;
        core_write_data = wdata;
        core_mem_write  = is_store;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (core_en) begin
                seen      = 1;
                mem_ready = 1'b0;
            end else if (mem_req) begin
                if (!fdone) begin
                    if (mem_addr !== pc || mem_we !== 1'b0) bad++;
                    if (fn == wf) begin
                        mem_ready = 1'b1;
                        mem_rdata = instr;
                        fdone     = 1;
                    end else begin
                        mem_ready = 1'b0;
                        mem_rdata = $urandom;
                    end
                    fn++;
                end else begin
                    if (mem_addr !== alu || mem_we !== is_store) bad++;
                    if (is_store && mem_wdata !== wdata) bad++;
                    if (dn == wd) begin
                        mem_ready = 1'b1;
                        mem_rdata = ldata;
                    end else begin
                        mem_ready = 1'b0;
                        mem_rdata = $urandom;
                    end
                    dn++;
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
        end
        exp_lat = 3 + wf + (is_mem ? (wd + 1) : 0);
        if (is_load) exp_rdata = ldata;
        check("commit_seen", 32'(seen), 32'd1);
        check("latency", 32'(cyc), 32'(exp_lat));
        check("fetch_req_cycles", 32'(fn), 32'(wf + 1));
        check("data_req_cycles", 32'(dn), 32'(is_mem ? (wd + 1) : 0));
        check("req_attrs_bad", 32'(bad), 32'd0);
        check("core_instr", core_instr, instr);
        check("core_read_data", core_read_data, exp_rdata);
        check("count_at_commit", instr_count, exp_count);
        check("bus_error_clear", 32'(bus_error), 32'd0);
        exp_count = exp_count + 32'd1;
    endtask

    initial begin
        logic [31:0] pc;
        logic [31:0] r;
        logic [6:0]  op;
        logic [31:0] instr;
        int          kind;
        int          reqs;
        int          ens;
        int          dw;
        bit          fd;

        repeat (3) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_core_en", 32'(core_en), 32'd0);
        check("rst_bus_error", 32'(bus_error), 32'd0);
        check("rst_core_instr", core_instr, 32'h00000013);
        check("rst_read_data", core_read_data, 32'd0);
        check("rst_count", instr_count, 32'd0);
        reset = 1'b1;
        check("boot_no_req", 32'(mem_req), 32'd0);

        run_instr(32'h0, 32'h00500093, 0, 0, 32'h0, 32'h0, 32'h0);
        run_instr(32'h4, 32'h0000A103, 0, 2, 32'h40, 32'h0, 32'hDEADBEEF);
        run_instr(32'h8, 32'h0020A023, 0, 0, 32'h80, 32'h12345678, $urandom);
        run_instr(32'hC, 32'h00500093, MAX_WAIT - 1, 0, 32'h0, 32'h0, 32'h0);
        run_instr(32'h10, 32'h0000A103, 1, MAX_WAIT - 1, 32'h44, 32'h0, 32'hCAFEF00D);

        pc = 32'h14;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            r    = $urandom;
            case (kind)
                0:       op = 7'b0000011;
                1:       op = 7'b0100011;
                default: begin
                    case ($urandom_range(0, 3))
                        0:       op = 7'b0010011;
                        1:       op = 7'b0110011;
                        2:       op = 7'b1101111;
                        default: op = 7'b0110111;
                    endcase
                end
            endcase
            instr = {r[31:7], op};
            run_instr(pc, instr, $urandom_range(0, 4), $urandom_range(0, 4),
                      {$urandom_range(0, 32'h3FFF), 2'b00}, $urandom, $urandom);
            pc = pc + 32'd4;
        end
        @(negedge clk);
        check("count_after_random", instr_count, exp_count);

        // Fetch timeout: ready never arrives.
        do_reset();
        core_pc = 32'h100;
        reqs = 0; ens = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req) reqs++;
            if (core_en) ens++;
        end
        check("timeout_req_cycles", 32'(reqs), 32'(MAX_WAIT));
        check("timeout_bus_error", 32'(bus_error), 32'd1);
        check("timeout_no_commit", 32'(ens), 32'd0);
        check("timeout_req_low", 32'(mem_req), 32'd0);
        check("timeout_count", instr_count, 32'd0);

        // Misaligned fetch.
        do_reset();
        core_pc   = 32'h102;
        mem_ready = 1'b1;
        reqs = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_req) reqs++;
        end
        mem_ready = 1'b0;
        check("misalign_no_req", 32'(reqs), 32'd0);
        check("misalign_bus_error", 32'(bus_error), 32'd1);
        check("misalign_count", instr_count, 32'd0);

        // Reset during a data wait.
        do_reset();
        run_instr(32'h0, 32'h00500093, 0, 0, 32'h0, 32'h0, 32'h0);
        core_pc = 32'h4; core_alu_result = 32'h40; core_mem_write = 1'b0;
        fd = 0; dw = 0;
        for (int k = 0; k < 20 && dw < 3; k++) begin
            @(negedge clk);
            if (mem_req && !fd) begin
                mem_ready = 1'b1;
                mem_rdata = 32'h0000A103;
                fd = 1;
            end else begin
                mem_ready = 1'b0;
                if (mem_req) dw++;
            end
        end
        check("mid_data_reached", 32'(dw), 32'd3);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_mem_req", 32'(mem_req), 32'd0);
        check("mid_rst_core_en", 32'(core_en), 32'd0);
        check("mid_rst_core_instr", core_instr, 32'h00000013);
        check("mid_rst_count", instr_count, 32'd0);
        check("mid_rst_read_data", core_read_data, 32'd0);
        @(negedge clk);
        reset   = 1'b1;
        core_pc = 32'h20;
        check("mid_rst_boot_idle", 32'(mem_req), 32'd0);
        @(negedge clk);
        check("mid_rst_fetch_req", 32'(mem_req), 32'd1);
        check("mid_rst_fetch_addr", mem_addr, 32'h20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/core_mem_sequencer.md
Name: core_mem_sequencer

Overview:
Multi-cycle sequencer that shares one single-port unified memory between instruction fetch and data access for the single-cycle RV32I core (clk/reset, pc, instr, read_data, mem_write, alu_result, write_data). It fetches each instruction, performs at most one data access, then pulses a commit enable so the core updates PC and register file exactly once per instruction. It also counts retired instructions and flags bus errors: timeout, and misaligned fetch.

Parameters:
MAX_WAIT, 16, maximum cycles a memory request may wait for mem_ready before a bus error (must be >= 2)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
core_pc  in  32  core program counter
core_mem_write  in  1  core store indication
core_alu_result  in  32  core data address
core_write_data  in  32  core store data
core_instr  out  32  registered instruction presented to core
core_read_data  out  32  registered load data presented to core
core_en  out  1  one-cycle commit pulse; core state updates only when 1
mem_req  out  1  memory request valid
mem_we  out  1  memory write enable (qualified by mem_req)
mem_addr  out  32  memory byte address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid when mem_req && mem_ready
mem_ready  in  1  memory completion; a transfer completes in any cycle with mem_req && mem_ready
bus_error  out  1  sticky error flag
instr_count  out  CNT_W  retired-instruction count

Behaviour:
- Moore FSM; all outputs decode from registers. States: BOOT, FETCH, DECODE, DATA, COMMIT, ERROR.
- Reset (reset=0, async): state=BOOT, instr_q=0x00000013 (NOP), rdata_q=0, wait_cnt=0, instr_count=0, err=0. Reset outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, core_en=0, bus_error=0, core_instr=0x00000013, core_read_data=0. Reset mid-transaction drops mem_req immediately. The pending transfer is abandoned.
- BOOT: exactly one cycle after reset release -> FETCH.
- FETCH: if core_pc[1:0]!=0 -> ERROR with no request issued. Otherwise mem_req=1, mem_we=0, mem_addr=core_pc. On mem_ready: instr_q<=mem_rdata -> DECODE.
- DECODE: one cycle for core combinational settle. If instr_q[6:0]==7'b0000011 (load) or 7'b0100011 (store) -> DATA, else -> COMMIT.
- DATA: mem_req=1, mem_addr=core_alu_result, mem_we=core_mem_write, mem_wdata=core_write_data. On mem_ready: for loads rdata_q<=mem_rdata; stores leave rdata_q unchanged. Then -> COMMIT.
- COMMIT: core_en=1 for exactly one cycle; instr_count<=instr_count+1, wrapping from all-ones to 0 -> FETCH.
- Address, we and wdata are stable for the whole request; mem_req never deasserts before completion except on reset or ERROR.
- Timeout: wait_cnt clears on entry to FETCH/DATA and increments each request cycle without mem_ready. If the cycle with wait_cnt==MAX_WAIT-1 also lacks mem_ready -> ERROR. mem_ready on that same cycle completes normally.
- ERROR: terminal until reset. bus_error=1, mem_req=0, core_en=0, counter frozen.
- Latency with zero-wait memory (ready in first request cycle): non-memory instruction 3 cycles (FETCH, DECODE, COMMIT); load/store 4 cycles. Each wait cycle adds 1.
- core_instr/core_read_data hold last values outside updates. mem_rdata is ignored when not (mem_req && mem_ready). mem_ready while mem_req=0 is ignored.

Decomposition:
- Package seq_pkg: state enum (BOOT, FETCH, DECODE, DATA, COMMIT, ERROR), OP_LOAD=7'b0000011, OP_STORE=7'b0100011, NOP_INSTR=32'h00000013.
- One sub-module: wait_timer. It holds the clear/increment counter with an expired output, parameterised by MAX_WAIT.

Test Plan:
- Zero-wait memory, pc=0, mem_rdata=0x00500093 (addi) -> mem_req high 1 cycle addr 0, core_en pulses on 3rd cycle after BOOT, instr_count=1, no data request.
- Load 0x0000A103 with alu_result=0x40, ready after 2 wait cycles in DATA returning 0xDEADBEEF -> mem_addr=0x40, mem_we=0 held 3 cycles, core_read_data=0xDEADBEEF at COMMIT, 6 cycles total.
- Store 0x0020A023 with alu_result=0x80, write_data=0x12345678, core_mem_write=1 -> one request with mem_we=1, addr 0x80, wdata 0x12345678; core_read_data unchanged.
- mem_ready held 0 in FETCH with MAX_WAIT=16 -> mem_req high exactly 16 cycles, then bus_error=1, mem_req=0, core_en never pulses; stays so until reset.
- core_pc=0x00000002 -> ERROR next cycle, mem_req never asserted, bus_error=1.
- Assert reset=0 mid-DATA wait -> mem_req/core_en drop asynchronously, core_instr=0x00000013, instr_count=0; after release, BOOT then FETCH at current core_pc.
